// File: rtl/trackball_quad_emu.sv
// trackball_quad_emu
//   Converts hps_io PS/2 mouse packets into per-axis trackball signals.
//   Each axis holds a signed, saturating motion accumulator. The accumulator
//   drains one unit per step opportunity. The prescaler creates one step
//   opportunity every STEP_DIV cycles. Each step advances a 2-bit phase and a
//   wrapping position counter.
//
// Ports
//   clk_sys    in   system clock
//   reset      in   synchronous, active-high
//   en         in   0 = ignore packets and freeze stepping (state held)
//   ps2_mouse  in   [24] toggle, [15:8]/[4] dX, [23:16]/[5] dY
//   quad_x/y   out  OUT_MODE 0: {dir, clk}; OUT_MODE 1: 2-bit Gray quadrature
//   pos_x/y    out  wrapping position counters
//   busy       out  either accumulator nonzero
module trackball_quad_emu #(
  parameter int ACC_W    = 12,
  parameter int STEP_DIV = 64,
  parameter int SHIFT    = 0,
  parameter int POS_W    = 4,
  parameter int OUT_MODE = 0,
  parameter int INV_X    = 0,
  parameter int INV_Y    = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             en,
  input  logic [24:0]      ps2_mouse,
  output logic [1:0]       quad_x,
  output logic [1:0]       quad_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             busy
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ONE     = (ACC_W+1)'(1);

  typedef struct packed {
    logic signed [ACC_W-1:0] acc;
    logic [1:0]              phase;
    logic [POS_W-1:0]        pos;
    logic                    dir;
  } axis_t;

  logic                    tog_q;
  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic                    pkt;
  logic signed [ACC_W-1:0] delta_x;
  logic signed [ACC_W-1:0] delta_y;
  axis_t                   ax_x;
  axis_t                   ax_y;
  axis_t                   nx_x;
  axis_t                   nx_y;
  logic                    unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

  // 9-bit two's complement delta -> ACC_W, scaled, optionally negated.
  function automatic logic signed [ACC_W-1:0] form_delta(input logic [8:0] raw,
                                                         input logic       inv);
    logic signed [ACC_W-1:0] d;
    d = {{(ACC_W-9){raw[8]}}, raw};
    d = d << SHIFT;
    if (inv) d = -d;
    return d;
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > ACC_MAX)      r = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) r = ACC_MIN[ACC_W-1:0];
    else                  r = v[ACC_W-1:0];
    return r;
  endfunction

  // Packet add and step drain are folded into one update at ACC_W+1 bits, so
  // a packet landing on a tick is never lost and only the final sum saturates.
  function automatic axis_t axis_step(input axis_t                   cur,
                                      input logic signed [ACC_W-1:0] d,
                                      input logic                    take,
                                      input logic                    tick_i);
    axis_t                 nx;
    logic signed [ACC_W:0] sum;
    logic                  stp;
    logic                  neg;
    nx  = cur;
    neg = cur.acc[ACC_W-1];
    stp = tick_i && (cur.acc != '0);
    sum = {cur.acc[ACC_W-1], cur.acc};
    if (take) sum = sum + {d[ACC_W-1], d};
    if (stp) begin
      sum      = neg ? sum + ONE : sum - ONE;
      nx.phase = neg ? cur.phase - 2'd1 : cur.phase + 2'd1;
      nx.pos   = neg ? cur.pos - POS_W'(1) : cur.pos + POS_W'(1);
      nx.dir   = ~neg;
    end
    nx.acc = sat(sum);
    return nx;
  endfunction

  function automatic logic [1:0] encode(input axis_t a);
    logic [1:0] q;
    if (OUT_MODE == 1) q = {a.phase[1], a.phase[1] ^ a.phase[0]};
    else               q = {a.dir, a.phase[0]};
    return q;
  endfunction

  // With en low both pkt and tick are low, so nx_* equals the held state.
  always_comb begin
    pkt     = en && (ps2_mouse[24] != tog_q);
    tick    = en && (cnt == CNT_LAST);
    delta_x = form_delta({ps2_mouse[4], ps2_mouse[15:8]}, INV_X != 0);
    delta_y = form_delta({ps2_mouse[5], ps2_mouse[23:16]}, INV_Y != 0);
    nx_x    = axis_step(ax_x, delta_x, pkt, tick);
    nx_y    = axis_step(ax_y, delta_y, pkt, tick);
  end

  // tog_q tracks the toggle in every cycle, reset included, so neither reset
  // nor a disabled period leaves a stale edge to be seen as a packet later.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_mouse[24];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt    <= '0;
      ax_x   <= '0;
      ax_y   <= '0;
      quad_x <= '0;
      quad_y <= '0;
      busy   <= 1'b0;
    end else begin
      if (en) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      ax_x   <= nx_x;
      ax_y   <= nx_y;
      quad_x <= encode(nx_x);
      quad_y <= encode(nx_y);
      busy   <= (nx_x.acc != '0) || (nx_y.acc != '0);
    end
  end

  assign pos_x = ax_x.pos;
  assign pos_y = ax_y.pos;

endmodule

// File: tb/tb_trackball_quad_emu.sv
// Bench for trackball_quad_emu.
// dut_a: ACC_W=10, STEP_DIV=4, Gray output.
// dut_b: STEP_DIV=4, legacy {dir,clk} output, Y inverted.
// Expected steps are queued by the stimulus. A monitor per DUT pops one
// entry on every output change and compares the outputs and the cycle.
module tb_trackball_quad_emu;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [24:0] ps2_a;
  logic [24:0] ps2_b;
  logic [1:0]  qx_a, qy_a, qx_b, qy_b;
  logic [3:0]  px_a, py_a, px_b, py_b;
  logic        busy_a, busy_b;

  longint cyc = 0;
  logic   rst_q = 1'b1;
  int     total = 0;
  int     bad = 0;

  typedef struct {
    logic [11:0] outs;   // {quad_x, quad_y, pos_x, pos_y}
    longint      at;
  } ev_t;
  ev_t q_a[$];
  ev_t q_b[$];

  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  trackball_quad_emu #(.ACC_W(10), .STEP_DIV(4), .SHIFT(0), .POS_W(4),
                       .OUT_MODE(1), .INV_X(0), .INV_Y(0)) dut_a (
    .clk_sys(clk), .reset(reset), .en(en), .ps2_mouse(ps2_a),
    .quad_x(qx_a), .quad_y(qy_a), .pos_x(px_a), .pos_y(py_a), .busy(busy_a));

  trackball_quad_emu #(.ACC_W(12), .STEP_DIV(4), .SHIFT(0), .POS_W(4),
                       .OUT_MODE(0), .INV_X(0), .INV_Y(1)) dut_b (
    .clk_sys(clk), .reset(reset), .en(en), .ps2_mouse(ps2_b),
    .quad_x(qx_b), .quad_y(qy_b), .pos_x(px_b), .pos_y(py_b), .busy(busy_b));

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit sel, input logic [1:0] qx, input logic [1:0] qy,
                      input logic [3:0] px, input logic [3:0] py, input longint at);
    ev_t e;
    e.outs = {qx, qy, px, py};
    e.at   = at;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Drive one packet (toggle flips) on the selected DUT at the current time.
  task automatic send(input bit sel, input int dx, input int dy);
    logic [24:0] p;
    logic [8:0]  bx, by;
    bx = dx[8:0];
    by = dy[8:0];
    p  = sel ? ps2_b : ps2_a;
    p[15:8]  = bx[7:0];
    p[4]     = bx[8];
    p[23:16] = by[7:0];
    p[5]     = by[8];
    p[24]    = ~p[24];
    if (sel) ps2_b = p;
    else     ps2_a = p;
  endtask

  // Returns at the negedge where reset is released (cycle 0, prescaler 0).
  task automatic do_reset();
    @(negedge clk);
    en    = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mon(input bit sel);
    logic [11:0] cur, prev;
    ev_t         e;
    string       nm;
    nm   = sel ? "b" : "a";
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sel ? {qx_b, qy_b, px_b, py_b} : {qx_a, qy_a, px_a, py_a};
      if (rst_q) begin
        prev = cur;
      end else if (cur !== prev) begin
        prev = cur;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL %s.unexpected_step: got outputs %0h expected no change (cycle %0d)",
                   nm, cur, cyc);
        end else begin
          e = sel ? q_b.pop_front() : q_a.pop_front();
          check({nm, ".step_outputs"}, {20'd0, cur}, {20'd0, e.outs});
          check({nm, ".step_cycle"}, 32'(cyc), 32'(e.at));
        end
      end
    end
  endtask

  initial begin
    longint c0;
    reset = 1'b1;
    en    = 1'b1;
    ps2_a = 25'h1000000;
    ps2_b = '0;
    fork
      mon(1'b0);
      mon(1'b1);
    join_none

    // Reset with toggle high, then a long idle: no phantom packet.
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("rst.quad_x", {30'd0, qx_a}, 0);
    check("rst.quad_y", {30'd0, qy_a}, 0);
    check("rst.pos_x", {28'd0, px_a}, 0);
    check("rst.pos_y", {28'd0, py_a}, 0);
    check("rst.busy", {31'd0, busy_a}, 0);
    repeat (1000) @(negedge clk);
    check("idle.busy", {31'd0, busy_a}, 0);
    check("idle.pos_x", {28'd0, px_a}, 0);

    // dX=+5: ticks in cycles 3,7,..,19 -> changes seen at c0+4k.
    do_reset();
    c0 = cyc;
    for (int k = 1; k <= 5; k++) push(1'b0, gray_tab[k % 4], 2'b00, 4'(k), 4'd0, c0 + 4 * k);
    send(1'b0, 5, 0);
    @(negedge clk);
    check("drain.busy_rise", {31'd0, busy_a}, 1);
    repeat (18) @(negedge clk);
    check("drain.busy_before_last", {31'd0, busy_a}, 1);
    @(negedge clk);
    check("drain.busy_fall", {31'd0, busy_a}, 0);
    check("drain.pos_x", {28'd0, px_a}, 5);
    repeat (20) @(negedge clk);
    check("drain.quad_y", {30'd0, qy_a}, 0);
    check("drain.pending", q_a.size(), 0);

    // acc=+2, then dX=-1 lands in the tick cycle: one step, acc -> 0.
    do_reset();
    c0 = cyc;
    push(1'b0, 2'b01, 2'b00, 4'd1, 4'd0, c0 + 4);
    send(1'b0, 2, 0);
    @(negedge clk);
    check("simul.busy_rise", {31'd0, busy_a}, 1);
    repeat (2) @(negedge clk);
    send(1'b0, -1, 0);
    @(negedge clk);
    check("simul.busy_fall", {31'd0, busy_a}, 0);
    repeat (30) @(negedge clk);
    check("simul.pos_x", {28'd0, px_a}, 1);
    check("simul.pending", q_a.size(), 0);

    // Six dX=+255 packets in cycles 0..5. The tick in cycle 3 steps once
    // while acc is already clamped at 511, so 511 steps still follow the
    // last packet: 512 steps in all, pos_x = 1 + 511 = 0 mod 16.
    do_reset();
    c0 = cyc;
    for (int i = 1; i <= 512; i++) push(1'b0, gray_tab[i % 4], 2'b00, 4'(i % 16), 4'd0, c0 + 4 * i);
    for (int p = 0; p < 6; p++) begin
      send(1'b0, 255, 0);
      @(negedge clk);
    end
    check("sat.pos_after_burst", {28'd0, px_a}, 1);
    check("sat.busy_after_burst", {31'd0, busy_a}, 1);
    repeat (2050) @(negedge clk);
    check("sat.busy_end", {31'd0, busy_a}, 0);
    check("sat.pos_x", {28'd0, px_a}, 0);
    check("sat.pending", q_a.size(), 0);

    // Packet while disabled is dropped; then +1 with a 50-cycle pause
    // that freezes the prescaler at 2.
    do_reset();
    en = 1'b0;
    send(1'b0, 4, 0);
    repeat (10) @(negedge clk);
    check("en.dropped_busy", {31'd0, busy_a}, 0);
    en = 1'b1;
    c0 = cyc;
    push(1'b0, 2'b01, 2'b00, 4'd1, 4'd0, c0 + 54);
    send(1'b0, 1, 0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (50) @(negedge clk);
    check("en.busy_held", {31'd0, busy_a}, 1);
    check("en.pos_held", {28'd0, px_a}, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("en.pos_x", {28'd0, px_a}, 1);
    check("en.busy_fall", {31'd0, busy_a}, 0);
    repeat (20) @(negedge clk);
    check("en.pending", q_a.size(), 0);

    // Legacy mode: dX=-2 (reverse), dY=-3 inverted to +3.
    do_reset();
    c0 = cyc;
    push(1'b1, 2'b01, 2'b11, 4'd15, 4'd1, c0 + 4);
    push(1'b1, 2'b00, 2'b10, 4'd14, 4'd2, c0 + 8);
    push(1'b1, 2'b00, 2'b11, 4'd14, 4'd3, c0 + 12);
    send(1'b1, -2, -3);
    repeat (20) @(negedge clk);
    check("legacy.busy", {31'd0, busy_b}, 0);
    check("legacy.pos_y", {28'd0, py_b}, 3);
    check("legacy.pos_x", {28'd0, px_b}, 14);
    check("legacy.pending", q_b.size(), 0);
    check("idle_b.pending", q_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trackball_quad_emu.md
# trackball_quad_emu

Parametrised PS/2-mouse-to-trackball emulator for the arcade cores. It converts relative mouse packets into per-axis quadrature (or legacy direction+clock) signals at a controlled step rate. It also keeps wrapping position counters for cores that read the trackball as a counter. It sits between `hps_io` (`ps2_mouse`) and the core's trackball inputs. It replaces ad-hoc inline trackball logic with saturation, rate control, sensitivity and inversion.

## Interface
Parameters:
- `ACC_W`, 12, signed accumulator width per axis; must be ≥ 10+`SHIFT`.
- `STEP_DIV`, 64, `clk_sys` cycles per step opportunity (≥1).
- `SHIFT`, 0, sensitivity; each delta is left-shifted by this amount before accumulation.
- `POS_W`, 4, position counter width.
- `OUT_MODE`, 0, output encoding: 0 = legacy `{dir, clk}`, 1 = 2-bit Gray quadrature.
- `INV_X`, 0, negate the X delta when 1.
- `INV_Y`, 0, negate the Y delta when 1.

Ports:
- `clk_sys` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `en` in 1: when 0, packets are ignored and stepping freezes; state is held.
- `ps2_mouse` in 25: hps_io format. [24] packet toggle, [15:8] dX low bits, [4] dX sign, [23:16] dY low bits, [5] dY sign.
- `quad_x` out 2: X output, encoding per `OUT_MODE`.
- `quad_y` out 2: Y output, encoding per `OUT_MODE`.
- `pos_x` out `POS_W`: wrapping X position.
- `pos_y` out `POS_W`: wrapping Y position.
- `busy` out 1: high while either accumulator is nonzero.

## Operation
- Packet detect:
  - `tog_q` is a register holding the previous `ps2_mouse[24]`.
  - A packet is accepted when `en` && `ps2_mouse[24] != tog_q`.
  - `tog_q` updates every cycle, including when `en`=0, so packets arriving while disabled are dropped and not replayed.
- Delta formation:
  - 9-bit signed deltas: dX = {[4],[15:8]}, dY = {[5],[23:16]}.
  - Each is sign-extended to `ACC_W`, shifted left by `SHIFT`, then negated if the axis `INV_*` is 1.
- Prescaler: counts 0..`STEP_DIV`-1 while `en`=1, wrapping to 0. `tick` is asserted in the cycle the count equals `STEP_DIV`-1.
- Step: on `tick`, each axis with acc ≠ 0 steps:
  - s = +1 if acc > 0, −1 if acc < 0.
  - `phase` += s (2-bit wrap), `pos` += s (`POS_W` wrap), `dir` <= (s = +1).
  - acc moves one unit toward 0.
- Accumulate: acc_next = sat(acc + delta_if_packet − s_if_step), computed at `ACC_W`+1 bits.
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - A packet and a step in the same cycle are combined in one update; neither is lost.
  - When saturated, excess motion is discarded, never wrapped.
- Output encoding:
  - Mode 1: quad = {phase[1], phase[1]^phase[0]}. Sequence forward is 00→01→11→10→00.
  - Mode 0: quad = {dir, phase[0]}, so the clock bit toggles once per step.
- Axes are fully independent and share only the prescaler.

## Timing
- Reset values: acc=0, phase=0, pos=0, dir=0, prescaler=0, `quad_x`=`quad_y`=00, `pos_*`=0, `busy`=0. `tog_q` loads the current `ps2_mouse[24]` so reset never creates a phantom packet.
- A reset asserted mid-stepping clears everything on the next edge; pending motion is lost.
- Packet latency: the accumulator updates on the edge after the toggle change is seen. `busy` rises on that same edge.
- Step latency: the first output change occurs on the first `tick` after the acc becomes nonzero. The worst case is `STEP_DIV` cycles.
- Step rate: at most one step per axis per `STEP_DIV` cycles. A delta of magnitude N drains in N ticks.
- All outputs are registered. `busy` = (acc_x ≠ 0) | (acc_y ≠ 0), registered.
- `en` falling mid-drain: the prescaler and accumulators hold their values. Stepping resumes with the held prescaler count when `en` rises.

## Test plan
- Reset & phantom check: hold `reset` 4 cycles with [24]=1, release, and keep [24] constant for 1000 cycles → no output activity, `busy`=0, `pos_x`=0.
- Positive X drain: `STEP_DIV`=4, mode 1, toggle a packet with dX=+5.
  - `quad_x` steps 00→01→11→10→00→01, one change every 4 cycles.
  - `pos_x`=5; `busy` drops after the 5th step.
  - Y stays at 00.
- Negative Y, legacy mode, `INV_Y`=1: packet with dY=−3 (sign=0 after inversion).
  - `quad_y[1]`=1 (dir positive); `quad_y[0]` toggles 3 times.
  - `pos_y`=3.
- Saturation: `ACC_W`=10, `STEP_DIV`=1000, send 6 packets of dX=+255 → acc clamps at 511. Exactly 511 steps follow, and `pos_x` = 511 mod 16 = 15.
- Simultaneous event: acc_x=+2, and a packet of dX=−1 arrives in the `tick` cycle → acc_x=0, exactly one forward step emitted, `busy` falls.
- Enable gating: `en`=0, send dX=+4, then `en`=1 → no steps, acc=0. Then send dX=+1 while draining with `en` toggled low for 50 cycles → stepping pauses and resumes, total of 1 step.
